// File: rtl/div_pkg.sv
// Shared constants and state encoding for the sequential 8-bit divider.
package div_pkg;
  localparam int DIV_W     = 8;
  localparam int ITER_LAST = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_t;
endpackage

// File: rtl/sub9_cla.sv
// 9-bit subtractor a - b built as a + ~b + 1 with flattened carry-lookahead.
module sub9_cla (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] diff,
  output logic       borrow
);
  logic [8:0] bn, g, p;
  logic [9:0] c;

  assign bn = ~b;
  assign g  = a & bn;
  assign p  = a ^ bn;

  // Each carry is the OR of every generate term propagated up to it, plus the
  // +1 carry-in propagated through all lower bits; no ripple dependency.
  always_comb begin
    c    = '0;
    c[0] = 1'b1;
    for (int i = 0; i < 9; i++) begin
      logic term;
      term = 1'b1;
      for (int k = 0; k <= i; k++) term = term & p[k];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int k = j + 1; k <= i; k++) term = term & p[k];
        c[i+1] = c[i+1] | term;
      end
    end
  end

  assign diff   = p ^ c[8:0];
  assign borrow = ~c[9];
endmodule

// File: rtl/seq_div8.sv
// Sequential 8-bit unsigned restoring divider: one quotient bit per cycle.
module seq_div8
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  div_state_t       state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] r_q, r_d, q_q, q_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d, rem_q, rem_d;
  logic             dz_q, dz_d, busy_q, busy_d, done_q, done_d;

  logic [8:0] trial, diff;
  logic       borrow;

  // Shift the next dividend bit into the partial remainder and try subtracting.
  assign trial = {r_q, q_q[WIDTH-1]};

  sub9_cla u_sub (
    .a      (trial),
    .b      ({1'b0, dvs_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  wire unused_diff_msb = diff[8];

  // Next-state and datapath updates; results only move on entry to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    q_d     = q_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dz_d    = dz_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (divisor != '0) begin
            dvs_d   = divisor;
            q_d     = dividend;
            r_d     = '0;
            cnt_d   = '0;
            dz_d    = 1'b0;
            state_d = CALC;
          end else begin
            quo_d   = '1;
            rem_d   = dividend;
            dz_d    = 1'b1;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        busy_d = 1'b1;
        r_d    = borrow ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        q_d    = {q_q[WIDTH-2:0], ~borrow};
        cnt_d  = cnt_q + 3'd1;
        if (cnt_q == 3'(ITER_LAST)) begin
          quo_d   = q_d;
          rem_d   = r_d;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      r_q     <= '0;
      q_q     <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dz_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dz_q    <= dz_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_seq_div8.sv
// Self-checking bench for seq_div8 against an arithmetic divide/modulo model.
module tb_seq_div8;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0, divisor = '0;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seq_div8 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  // Expected result from plain arithmetic.
  function automatic void model(input int a, input int b, output int q, output int r, output bit dz);
    if (b == 0) begin q = 255; r = a; dz = 1; end
    else begin q = a / b; r = a % b; dz = 0; end
  endfunction

  // Issue one operation from IDLE; measure latency, busy length and result stability.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat, output int nbusy,
                        output logic [7:0] q, output logic [7:0] r, output logic dz, output bit stable);
    logic [7:0] q0, r0;
    int k;
    q0 = quotient; r0 = remainder; stable = 1;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; nbusy = 0;
    if (busy) nbusy++;
    while (!done && k < 20) begin
      if (quotient !== q0 || remainder !== r0) stable = 0;
      @(posedge clk); #1;
      k++;
      if (busy) nbusy++;
    end
    lat = k + 1;
    q = quotient; r = remainder; dz = div_by_zero;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    int a_t[7] = '{100, 255, 255, 3, 0, 5, 9};
    int b_t[7] = '{7,   1,   255, 200, 9, 0, 3};
    int lat, nb, eq, er; bit edz, st;
    logic [7:0] q, r; logic dz;
    for (int i = 0; i < 7; i++) begin
      model(a_t[i], b_t[i], eq, er, edz);
      run_op(8'(a_t[i]), 8'(b_t[i]), lat, nb, q, r, dz, st);
      n_checks++;
      if (q !== 8'(eq) || r !== 8'(er) || dz !== edz) begin
        n_fail++;
        $display("FAIL directed_result %0d/%0d: got q=%0d r=%0d dz=%b, want q=%0d r=%0d dz=%b",
                 a_t[i], b_t[i], q, r, dz, eq, er, edz);
      end
      n_checks++;
      if (lat != (b_t[i] == 0 ? 1 : 9) || nb != lat) begin
        n_fail++;
        $display("FAIL directed_timing %0d/%0d: got latency=%0d busy_cycles=%0d, want %0d",
                 a_t[i], b_t[i], lat, nb, b_t[i] == 0 ? 1 : 9);
      end
    end
  endtask

  task automatic test_random();
    int lat, nb, eq, er; bit edz, st;
    logic [7:0] a, b, q, r; logic dz;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom);
      b = (i % 8 == 3) ? 8'd0 : 8'($urandom);
      model(a, b, eq, er, edz);
      run_op(a, b, lat, nb, q, r, dz, st);
      n_checks++;
      if (q !== 8'(eq) || r !== 8'(er) || dz !== edz || !st) begin
        n_fail++;
        $display("FAIL random_result %0d/%0d: got q=%0d r=%0d dz=%b stable=%0d, want q=%0d r=%0d dz=%b stable=1",
                 a, b, q, r, dz, st, eq, er, edz);
      end
    end
  endtask

  task automatic test_ignore_start();
    int k;
    start = 1'b1; dividend = 8'd200; divisor = 8'd9;
    @(posedge clk); #1;
    dividend = 8'd50; divisor = 8'd6;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 20) begin @(posedge clk); #1; k++; end
    n_checks++;
    if (!done || quotient !== 8'd22 || remainder !== 8'd2 || div_by_zero !== 1'b0 || k != 7) begin
      n_fail++;
      $display("FAIL ignore_start: got done=%b q=%0d r=%0d dz=%b wait=%0d, want done=1 q=22 r=2 dz=0 wait=7",
               done, quotient, remainder, div_by_zero, k);
    end
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL ignore_requeue: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_back_to_back();
    int last, pulses, cyc;
    logic [7:0] a, b;
    a = 8'($urandom); b = 8'($urandom_range(255, 1));
    start = 1'b1; dividend = a; divisor = b;
    last = -1; pulses = 0; cyc = 0;
    while (pulses < 4 && cyc < 80) begin
      @(posedge clk); #1; cyc++;
      if (done) begin
        n_checks++;
        if (quotient !== a / b || remainder !== a % b || (last >= 0 && cyc - last != 10)) begin
          n_fail++;
          $display("FAIL back_to_back %0d/%0d: got q=%0d r=%0d gap=%0d, want q=%0d r=%0d gap=10",
                   a, b, quotient, remainder, last >= 0 ? cyc - last : 10, a / b, a % b);
        end
        last = cyc; pulses++;
      end
    end
    start = 1'b0;
    n_checks++;
    if (pulses != 4) begin
      n_fail++;
      $display("FAIL back_to_back_timeout: got %0d done pulses, want 4", pulses);
    end
    repeat (12) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int lat, nb; logic [7:0] q, r; logic dz; bit st;
    start = 1'b1; dividend = 8'd200; divisor = 8'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== 19'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got busy=%b done=%b q=%0d r=%0d dz=%b, want all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(8'd77, 8'd10, lat, nb, q, r, dz, st);
    n_checks++;
    if (q !== 8'd7 || r !== 8'd7 || dz !== 1'b0 || lat != 9) begin
      n_fail++;
      $display("FAIL after_reset 77/10: got q=%0d r=%0d dz=%b lat=%0d, want q=7 r=7 dz=0 lat=9",
               q, r, dz, lat);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
